// File: rtl/fp16_pkg.sv
// Shared binary16 field widths, special constants and the sequencer state encoding
// for the multi-cycle half-precision subtractor.
package fp16_pkg;

    localparam int EXP_W  = 5;
    localparam int FRAC_W = 10;
    localparam int SIG_W  = FRAC_W + 2;   // hidden + fraction + guard
    localparam int SUM_W  = SIG_W + 1;    // one carry bit on top

    localparam logic [15:0]      QNAN    = 16'h7E00;
    localparam logic [EXP_W-1:0] EXP_MAX = 5'h1F;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/fp16_classify.sv
// Purely combinational field decode of one binary16 value into sign, exponent,
// fraction and the zero / inf / NaN / subnormal class flags.
module fp16_classify
    import fp16_pkg::*;
(
    input  logic [15:0]       x,
    output logic              sign,
    output logic [EXP_W-1:0]  exp,
    output logic [FRAC_W-1:0] frac,
    output logic              is_zero,
    output logic              is_inf,
    output logic              is_nan,
    output logic              is_sub
);

    logic exp_zero;
    logic exp_ones;
    logic frac_zero;

    assign sign = x[15];
    assign exp  = x[14:10];
    assign frac = x[9:0];

    assign exp_zero  = (exp == '0);
    assign exp_ones  = (exp == EXP_MAX);
    assign frac_zero = (frac == '0);

    assign is_zero = exp_zero && frac_zero;
    assign is_sub  = exp_zero && !frac_zero;
    assign is_inf  = exp_ones && frac_zero;
    assign is_nan  = exp_ones && !frac_zero;

endmodule

// File: rtl/fp16_sub_seq.sv
// Multi-cycle binary16 subtractor (a - b, truncating) with valid/ready handshakes:
// special operands resolve straight to DONE, all others walk ALIGN -> ADD -> NORM.
module fp16_sub_seq
    import fp16_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result
);

    logic              sa, sb_raw, sb;
    logic [EXP_W-1:0]  ea, eb;
    logic [FRAC_W-1:0] fa, fb;
    logic              a_zero, a_inf, a_nan, a_sub;
    logic              b_zero, b_inf, b_nan, b_sub;

    fp16_classify u_cls_a (
        .x       (a),
        .sign    (sa),
        .exp     (ea),
        .frac    (fa),
        .is_zero (a_zero),
        .is_inf  (a_inf),
        .is_nan  (a_nan),
        .is_sub  (a_sub)
    );

    fp16_classify u_cls_b (
        .x       (b),
        .sign    (sb_raw),
        .exp     (eb),
        .frac    (fb),
        .is_zero (b_zero),
        .is_inf  (b_inf),
        .is_nan  (b_nan),
        .is_sub  (b_sub)
    );

    // Subtraction is addition of b with its sign inverted.
    assign sb = ~sb_raw;

    state_t state_q, state_d;

    logic [SIG_W-1:0] sig_l, sig_s;
    logic [EXP_W-1:0] exp_r, diff_r;
    logic             sign_r, op_sub;
    logic [SUM_W-1:0] sum_r;
    logic [15:0]      result_r;

    logic             capture;
    logic [EXP_W-1:0] ea_eff, eb_eff;
    logic [SIG_W-1:0] sig_a, sig_b;
    logic             a_big;
    logic             spec_hit;
    logic [15:0]      spec_res;

    assign capture = in_valid && in_ready;

    // Subnormals have no hidden bit and behave as exponent 1.
    assign ea_eff = a_sub ? 5'd1 : ea;
    assign eb_eff = b_sub ? 5'd1 : eb;
    assign sig_a  = {!a_sub, fa, 1'b0};
    assign sig_b  = {!b_sub, fb, 1'b0};
    assign a_big  = (ea_eff > eb_eff) || ((ea_eff == eb_eff) && (sig_a >= sig_b));

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        spec_hit = a_nan || b_nan || a_inf || b_inf || a_zero || b_zero;
        spec_res = 16'h0000;
        if (a_nan || b_nan) begin
            spec_res = QNAN;
        end else if (a_inf && b_inf) begin
            spec_res = (sa == sb) ? {sa, EXP_MAX, 10'h000} : QNAN;
        end else if (a_inf) begin
            spec_res = {sa, EXP_MAX, 10'h000};
        end else if (b_inf) begin
            spec_res = {sb, EXP_MAX, 10'h000};
        end else if (a_zero && b_zero) begin
            spec_res = (sa == sb) ? {sa, 15'h0000} : 16'h0000;
        end else if (a_zero) begin
            spec_res = {sb, b[14:0]};
        end else if (b_zero) begin
            spec_res = a;
        end
    end

    logic        norm_done;
    logic [5:0]  exp_inc;
    logic [15:0] norm_res;

    assign norm_done = (sum_r == '0) || sum_r[SUM_W-1] || sum_r[SUM_W-2] || (exp_r <= 5'd1);
    assign exp_inc   = {1'b0, exp_r} + 6'd1;

    always_comb begin
        norm_res = 16'h0000;
        if (sum_r == '0) begin
            norm_res = 16'h0000;
        end else if (sum_r[12]) begin
            norm_res = (exp_inc >= 6'd31) ? {sign_r, EXP_MAX, 10'h000}
                                          : {sign_r, exp_inc[4:0], sum_r[11:2]};
        end else if (sum_r[11]) begin
            norm_res = {sign_r, exp_r, sum_r[10:1]};
        end else begin
            norm_res = {sign_r, 5'd0, sum_r[10:1]};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (capture) state_d = spec_hit ? DONE : ALIGN;
            ALIGN:   if (diff_r == '0) state_d = ADD;
            ADD:     state_d = NORM;
            NORM:    if (norm_done) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_l    <= '0;
            sig_s    <= '0;
            exp_r    <= '0;
            diff_r   <= '0;
            sign_r   <= 1'b0;
            op_sub   <= 1'b0;
            sum_r    <= '0;
            result_r <= 16'h0000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (capture) begin
                        sig_l  <= a_big ? sig_a : sig_b;
                        sig_s  <= a_big ? sig_b : sig_a;
                        exp_r  <= a_big ? ea_eff : eb_eff;
                        diff_r <= a_big ? (ea_eff - eb_eff) : (eb_eff - ea_eff);
                        sign_r <= a_big ? sa : sb;
                        op_sub <= (sa != sb);
                        sum_r  <= '0;
                        if (spec_hit) result_r <= spec_res;
                    end
                end
                ALIGN: begin
                    if (diff_r >= 5'd12) begin
                        sig_s  <= '0;
                        diff_r <= '0;
                    end else if (diff_r != '0) begin
                        sig_s  <= sig_s >> 1;
                        diff_r <= diff_r - 5'd1;
                    end
                end
                ADD: begin
                    sum_r <= op_sub ? ({1'b0, sig_l} - {1'b0, sig_s})
                                    : ({1'b0, sig_l} + {1'b0, sig_s});
                end
                NORM: begin
                    if (norm_done) begin
                        result_r <= norm_res;
                    end else begin
                        sum_r <= sum_r << 1;
                        exp_r <= exp_r - 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_r;

endmodule

// File: tb/tb_fp16_sub_seq.sv
// Directed self-checking bench for fp16_sub_seq: hand-computed a-b vectors,
// special cases, latency bounds, output back-pressure and reset mid-operation.
module tb_fp16_sub_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    fp16_sub_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one operation, keep junk on in_valid/a/b while busy, check latency,
    // result, optional hold with out_ready low, then complete the handshake.
    task automatic do_op(input string tag, input logic [15:0] op_a, input logic [15:0] op_b,
                         input logic [15:0] exp_res, input int max_lat, input bit exact,
                         input int hold);
        int cycles;
        @(negedge clk);
        check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        a        = op_a;
        b        = op_b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        a = 16'($urandom);
        b = 16'($urandom);
        @(negedge clk);
        cycles = 1;
        while (!out_valid && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        in_valid = 1'b0;
        if (exact) check({tag, "_lat"}, cycles, max_lat);
        else       check({tag, "_lat_le"}, {31'd0, (cycles <= max_lat)}, 32'd1);
        check({tag, "_res"}, {16'd0, result}, {16'd0, exp_res});
        check({tag, "_done_hs"}, {30'd0, out_valid, in_ready}, 32'd2);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold"}, {14'd0, out_valid, in_ready, result}, {14'd0, 2'b10, exp_res});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_release"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 16'h0000;
        b         = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_state", {15'd0, out_valid, result}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release", {14'd0, in_ready, out_valid, result}, {14'd0, 2'b10, 16'h0000});

        do_op("one_minus_half", 16'h3C00, 16'h3800, 16'h3800, 27, 1'b0, 0);
        do_op("overflow_inf",   16'h7BFF, 16'hFBFF, 16'h7C00, 27, 1'b0, 0);
        do_op("inf_minus_inf",  16'h7C00, 16'h7C00, 16'h7E00, 1,  1'b1, 0);
        do_op("x_minus_x",      16'h3C00, 16'h3C00, 16'h0000, 27, 1'b0, 0);
        do_op("to_subnormal",   16'h0400, 16'h0001, 16'h03FF, 27, 1'b0, 0);
        do_op("deep_norm",      16'h3C01, 16'h3C00, 16'h1400, 27, 1'b0, 0);
        do_op("nan_in",         16'h7E01, 16'h3C00, 16'h7E00, 1,  1'b1, 0);
        do_op("single_inf_b",   16'h3C00, 16'h7C00, 16'hFC00, 1,  1'b1, 0);
        do_op("zero_zero",      16'h0000, 16'h0000, 16'h0000, 1,  1'b1, 0);
        do_op("nzero_zero",     16'h8000, 16'h0000, 16'h8000, 1,  1'b1, 0);
        do_op("zero_a",         16'h0000, 16'h3C00, 16'hBC00, 1,  1'b1, 0);
        do_op("zero_b",         16'h4000, 16'h8000, 16'h4000, 1,  1'b1, 0);
        do_op("far_shift",      16'h3C00, 16'h8001, 16'h3C00, 27, 1'b0, 0);
        do_op("carry_out",      16'h3C00, 16'hBC00, 16'h4000, 27, 1'b0, 0);
        do_op("b_larger",       16'h3800, 16'h3C00, 16'hB800, 27, 1'b0, 0);
        do_op("backpressure",   16'h4400, 16'h3C00, 16'h4200, 27, 1'b0, 10);

        // Reset while normalising a long cancellation.
        @(negedge clk);
        a        = 16'h3C01;
        b        = 16'h3C00;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out", {15'd0, out_valid, result}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_release", {30'd0, in_ready, out_valid}, 32'd2);
        repeat (15) @(negedge clk);
        check("no_stale", {15'd0, out_valid, result}, 32'd0);
        do_op("after_reset", 16'h4000, 16'h3C00, 16'h3C00, 27, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp16_sub_seq.md
FP16_SUB_SEQ -- requirements
Module: fp16_sub_seq

Interface
Parameters: none.
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port in_valid, input, 1 bit: operands a/b are valid.
REQ-004 SHALL have port in_ready, output, 1 bit: block accepts operands (high only in IDLE).
REQ-005 SHALL have port a, input, 16 bits: minuend, IEEE binary16.
REQ-006 SHALL have port b, input, 16 bits: subtrahend, IEEE binary16.
REQ-007 SHALL have port out_valid, output, 1 bit: result is valid (high only in DONE).
REQ-008 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-009 SHALL have port result, output, 16 bits: a minus b, binary16, truncated (round toward zero).

Function
REQ-010 SHALL compute a-b as a+(-b), with b sign inverted at capture; the operand registers SHALL capture a and b on the cycle where in_valid and in_ready are both high.
REQ-011 SHALL implement the states IDLE, ALIGN, ADD, NORM and DONE; IDLE->ALIGN on capture, or IDLE->DONE when the operands are a special case.
REQ-012 Special cases, resolved in one cycle to DONE: any NaN -> 16'h7E00; inf minus inf of equal sign -> 16'h7E00; a single inf -> that inf with its effective sign; both zero -> +0 unless the effective signs are equal, in which case the shared sign is kept; a zero -> the other operand (with sign flipped if it is b).
REQ-013 Significand: {hidden,frac10,guard} is 12 bits; hidden=0 and effective exponent=1 for subnormals.
REQ-014 Larger magnitude is ordered by exponent, then by significand; a tie selects a; the result exponent starts at the larger exponent.
REQ-015 ALIGN SHALL shift the smaller significand right 1 bit per cycle until exp_diff reaches 0; exp_diff>=12 SHALL zero it in one cycle; exp_diff=0 SHALL spend exactly 1 cycle in ALIGN.
REQ-016 ADD (1 cycle) SHALL add the 13-bit significands for equal effective signs and subtract smaller from larger otherwise; the result sign is the larger operand's effective sign.
REQ-017 NORM: zero sum -> +0; bit12 set -> exp+1 and frac=sum[11:2], with exp>=31 giving a signed inf (16'h7C00/FC00).
REQ-018 NORM otherwise SHALL shift left and decrement exp, 1 per cycle, while sum[11]=0 and exp>1.
REQ-019 On NORM exit with sum[11]=0, the result SHALL be encoded with exponent field 0 (subnormal) and frac=sum[10:1]; otherwise the exponent is exp and frac=sum[10:1].
REQ-020 Worst-case latency from capture to out_valid SHALL be no more than 27 cycles; the special-case path SHALL take exactly 1 cycle.
REQ-021 DONE SHALL hold out_valid and result stable until out_ready is high, then return to IDLE; in_ready SHALL be low in DONE, with no back-to-back overlap.
REQ-022 in_valid outside IDLE SHALL be ignored; a, b and in_valid may change freely after capture.

Reset
REQ-023 rst_n low SHALL force IDLE, in_ready=1 after release, out_valid=0, result=16'h0000, and clear all datapath registers.
REQ-024 Reset mid-operation SHALL abandon the operation; no stale result SHALL appear after release.

Structure
REQ-025 Package fp16_pkg SHALL hold the field widths, the constants (16'h7E00 NaN, 5'h1F max exponent) and the state enum.
REQ-026 The combinational sub-module fp16_classify SHALL decode sign, exponent, frac and the zero/inf/nan/subnormal flags; it is instantiated twice.

Verification
REQ-027 a=3C00, b=3800 -> result 3800 (1.0-0.5), out_valid within 27 cycles.
REQ-028 a=7BFF, b=FBFF -> result 7C00 (overflow to +inf).
REQ-029 a=7C00, b=7C00 -> 7E00 in 1 cycle; a=3C00, b=3C00 -> 0000.
REQ-030 a=0400, b=0001 -> 03FF (normal minus subnormal yields subnormal).
REQ-031 With out_ready held low for 10 cycles, result/out_valid SHALL be stable and in_ready SHALL be 0; the handshake completes on the following out_ready.
REQ-032 rst_n asserted during NORM -> out_valid=0 immediately, in_ready=1 after release, next op a=4000, b=3C00 -> 3C00.
